// File: rtl/ir_nec_receiver.sv
// NEC IR decoder: 2-FF sync + edge detect, pulse widths timed in 10 us ticks, one-cycle key strobes on led_db.
// Frame results strobe 5 clk after the stop-mark rise; width errors strobe 4 clk after the measuring edge.
module ir_nec_receiver #(
  parameter int         TICK_DIV   = 500,
  parameter bit         CHECK_ADDR = 1'b1,
  parameter logic [7:0] ADDR       = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ir_in,
  output logic [7:0] led_db,
  output logic       code_valid,
  output logic [7:0] cmd,
  output logic       repeat_pulse,
  output logic       frame_err
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LEAD_LOW  = 3'd1;
  localparam logic [2:0] S_LEAD_HIGH = 3'd2;
  localparam logic [2:0] S_BIT_LOW   = 3'd3;
  localparam logic [2:0] S_BIT_HIGH  = 3'd4;
  localparam logic [2:0] S_STOP      = 3'd5;
  localparam logic [2:0] S_CHECK     = 3'd6;

  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic          rise_q, rise_d, fall_q, fall_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [15:0]   dur_q, dur_d;
  logic [2:0]    state_q, state_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [31:0]   shift_q, shift_d;
  logic          rpt_q, rpt_d;
  logic [7:0]    led_q, led_d, cmd_q, cmd_d;
  logic          cv_q, cv_d, rp_q, rp_d, fe_q, fe_d;
  logic          tick, any_edge, timeout, frame_ok, bit_v;

  function automatic logic in_win(input logic [15:0] d, input logic [15:0] lo, input logic [15:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  function automatic logic [7:0] key_map(input logic [7:0] c);
    case (c)
      8'h16: key_map = 8'hC0;
      8'h0C: key_map = 8'hF9;
      8'h18: key_map = 8'hA4;
      8'h5E: key_map = 8'hB0;
      8'h08: key_map = 8'h99;
      8'h1C: key_map = 8'h92;
      8'h5A: key_map = 8'h82;
      8'h42: key_map = 8'hF8;
      8'h52: key_map = 8'h80;
      8'h4A: key_map = 8'h90;
      8'h44: key_map = 8'hA0;
      8'h40: key_map = 8'h83;
      8'h43: key_map = 8'hC6;
      8'h07: key_map = 8'hA1;
      8'h15: key_map = 8'h86;
      default: key_map = 8'hFF;
    endcase
  endfunction

  always_comb begin
    sync1_d    = ir_in;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    rise_d     = sync2_q & ~prev_q;
    fall_d     = ~sync2_q & prev_q;
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    any_edge   = rise_q | fall_q;
    if (any_edge)
      dur_d = 16'd0;
    else if (tick && (dur_q != 16'hFFFF))
      dur_d = dur_q + 16'd1;
    else
      dur_d = dur_q;
  end

  // Byte order in shift_q after 32 LSB-first shifts: [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd.
  assign frame_ok = (shift_q[31:24] == ~shift_q[23:16]) &&
                    (!CHECK_ADDR || ((shift_q[7:0] == ADDR) && (shift_q[15:8] == ~ADDR)));
  assign timeout  = (state_q != S_IDLE) && (dur_q > 16'd1000);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rpt_d     = rpt_q;
    cmd_d     = cmd_q;
    led_d     = 8'hFF;
    cv_d      = 1'b0;
    rp_d      = 1'b0;
    fe_d      = 1'b0;
    bit_v     = 1'b0;
    if (timeout) begin
      state_d = S_IDLE;
      fe_d    = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (fall_q) state_d = S_LEAD_LOW;
        S_LEAD_LOW: if (rise_q) begin
          if (in_win(dur_q, 16'd800, 16'd1000)) state_d = S_LEAD_HIGH;
          else begin state_d = S_IDLE; fe_d = 1'b1; end
        end
        S_LEAD_HIGH: if (fall_q) begin
          if (in_win(dur_q, 16'd400, 16'd500)) begin
            state_d = S_BIT_LOW; bit_cnt_d = 5'd0; rpt_d = 1'b0;
          end else if (in_win(dur_q, 16'd180, 16'd270)) begin
            state_d = S_STOP; rpt_d = 1'b1;
          end else begin
            state_d = S_IDLE; fe_d = 1'b1;
          end
        end
        S_BIT_LOW: if (rise_q) begin
          if (in_win(dur_q, 16'd40, 16'd72)) state_d = S_BIT_HIGH;
          else begin state_d = S_IDLE; fe_d = 1'b1; end
        end
        S_BIT_HIGH: if (fall_q) begin
          if (in_win(dur_q, 16'd40, 16'd72) || in_win(dur_q, 16'd140, 16'd200)) begin
            bit_v     = in_win(dur_q, 16'd140, 16'd200);
            shift_d   = {bit_v, shift_q[31:1]};
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = (bit_cnt_q == 5'd31) ? S_STOP : S_BIT_LOW;
          end else begin
            state_d = S_IDLE; fe_d = 1'b1;
          end
        end
        S_STOP: if (rise_q) begin
          if (in_win(dur_q, 16'd40, 16'd72)) state_d = S_CHECK;
          else begin state_d = S_IDLE; fe_d = 1'b1; end
        end
        S_CHECK: begin
          state_d = S_IDLE;
          if (rpt_q) rp_d = 1'b1;
          else if (frame_ok) begin
            cv_d  = 1'b1;
            cmd_d = shift_q[23:16];
            led_d = key_map(shift_q[23:16]);
          end else fe_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      tick_cnt_q <= '0;
      dur_q      <= 16'd0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 5'd0;
      shift_q    <= 32'd0;
      rpt_q      <= 1'b0;
      led_q      <= 8'hFF;
      cmd_q      <= 8'h00;
      cv_q       <= 1'b0;
      rp_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      tick_cnt_q <= tick_cnt_d;
      dur_q      <= dur_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rpt_q      <= rpt_d;
      led_q      <= led_d;
      cmd_q      <= cmd_d;
      cv_q       <= cv_d;
      rp_q       <= rp_d;
      fe_q       <= fe_d;
    end
  end

  assign led_db       = led_q;
  assign code_valid   = cv_q;
  assign cmd          = cmd_q;
  assign repeat_pulse = rp_q;
  assign frame_err    = fe_q;

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Bench for ir_nec_receiver: two instances (address check on/off) share one randomized NEC stream.
// One tick per clock; expected strobes are scheduled per cycle from the frame contents.
`timescale 1ns/1ps
module tb_ir_nec_receiver;

  localparam logic [7:0] TB_ADDR = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ir_in = 1'b1;
  logic [7:0] led_a, cmd_a, led_b, cmd_b;
  logic       cv_a, rp_a, fe_a, cv_b, rp_b, fe_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int ev_a[int];
  int ev_b[int];
  logic [7:0] exp_cmd_a = 8'h00;
  logic [7:0] exp_cmd_b = 8'h00;

  int n_cv_a = 0, n_rp_a = 0, n_fe_a = 0, n_cv_b = 0, n_rp_b = 0, n_fe_b = 0, n_led_b = 0;
  logic [7:0] last_led_a = 8'hFF;

  logic [7:0] key_cmd[15] = '{8'h16, 8'h0C, 8'h18, 8'h5E, 8'h08, 8'h1C, 8'h5A, 8'h42,
                              8'h52, 8'h4A, 8'h44, 8'h40, 8'h43, 8'h07, 8'h15};
  logic [7:0] key_led[15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'hA0, 8'h83, 8'hC6, 8'hA1, 8'h86};

  ir_nec_receiver #(.TICK_DIV(1), .CHECK_ADDR(1'b1), .ADDR(TB_ADDR)) dut_a (
    .clk(clk), .reset(reset), .ir_in(ir_in), .led_db(led_a), .code_valid(cv_a),
    .cmd(cmd_a), .repeat_pulse(rp_a), .frame_err(fe_a));

  ir_nec_receiver #(.TICK_DIV(1), .CHECK_ADDR(1'b0), .ADDR(TB_ADDR)) dut_b (
    .clk(clk), .reset(reset), .ir_in(ir_in), .led_db(led_b), .code_valid(cv_b),
    .cmd(cmd_b), .repeat_pulse(rp_b), .frame_err(fe_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] map_key(input logic [7:0] c);
    logic [7:0] r;
    r = 8'hFF;
    for (int i = 0; i < 15; i++) if (key_cmd[i] == c) r = key_led[i];
    return r;
  endfunction

  // Event code: kind*256 + cmd, kind 1 = accepted frame, 2 = repeat, 3 = error.
  function automatic logic [18:0] exp_vec(input int code, input logic [7:0] held_cmd);
    int kind;
    logic [7:0] c;
    kind = code / 256;
    c    = code[7:0];
    case (kind)
      1: return {map_key(c), 1'b1, 1'b0, 1'b0, held_cmd};
      2: return {8'hFF, 1'b0, 1'b1, 1'b0, held_cmd};
      3: return {8'hFF, 1'b0, 1'b0, 1'b1, held_cmd};
      default: return {8'hFF, 1'b0, 1'b0, 1'b0, held_cmd};
    endcase
  endfunction

  always @(negedge clk) begin
    int code_a, code_b;
    code_a = 0;
    code_b = 0;
    if (!reset) begin
      exp_cmd_a = 8'h00;
      exp_cmd_b = 8'h00;
    end else begin
      if (ev_a.exists(cyc)) code_a = ev_a[cyc];
      if (ev_b.exists(cyc)) code_b = ev_b[cyc];
      if (code_a / 256 == 1) exp_cmd_a = code_a[7:0];
      if (code_b / 256 == 1) exp_cmd_b = code_b[7:0];
    end
    chk("dut_a_outputs", int'({led_a, cv_a, rp_a, fe_a, cmd_a}), int'(exp_vec(code_a, exp_cmd_a)));
    chk("dut_b_outputs", int'({led_b, cv_b, rp_b, fe_b, cmd_b}), int'(exp_vec(code_b, exp_cmd_b)));
    chk("dut_a_one_strobe", int'((32'(cv_a) + 32'(rp_a) + 32'(fe_a)) <= 1), 1);
    if (cv_a) begin n_cv_a++; last_led_a = led_a; end
    if (rp_a) n_rp_a++;
    if (fe_a) n_fe_a++;
    if (cv_b) n_cv_b++;
    if (rp_b) n_rp_b++;
    if (fe_b) n_fe_b++;
    if (led_b != 8'hFF) n_led_b++;
  end

  function automatic int rr(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic drive(input logic lvl, input int n);
    ir_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sched(input int at, input int kind_a, input int kind_b, input logic [7:0] c);
    ev_a[at] = kind_a * 256 + int'(c);
    ev_b[at] = kind_b * 256 + int'(c);
  endtask

  task automatic leader_and_bits(input logic [31:0] w, input int nbits);
    drive(1'b0, rr(820, 900));
    drive(1'b1, rr(410, 490));
    for (int i = 0; i < nbits; i++) begin
      drive(1'b0, rr(44, 64));
      drive(1'b1, w[i] ? rr(145, 175) : rr(44, 64));
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] ai,
                            input logic [7:0] c, input logic [7:0] ci);
    logic ok_a, ok_b;
    leader_and_bits({ci, c, ai, a}, 32);
    drive(1'b0, rr(44, 64));
    ir_in = 1'b1;
    ok_b = (ci == ~c);
    ok_a = ok_b && (a == TB_ADDR) && (ai == ~TB_ADDR);
    sched(cyc + 5, ok_a ? 1 : 3, ok_b ? 1 : 3, c);
    drive(1'b1, 300);
  endtask

  task automatic send_repeat();
    drive(1'b0, rr(820, 900));
    drive(1'b1, rr(190, 260));
    drive(1'b0, rr(44, 64));
    ir_in = 1'b1;
    sched(cyc + 5, 2, 2, 8'h00);
    drive(1'b1, 300);
  endtask

  initial begin
    #(95000 * 10);
    n_err++;
    $display("FAIL watchdog: cycle budget expired at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int s_cv, s_rp, s_fe, s_cvb, s_feb, s_ledb;
    logic [7:0] c, a;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", int'(led_a), 8'hFF);
    chk("reset_cmd", int'(cmd_a), 8'h00);
    chk("reset_strobes", int'({cv_a, rp_a, fe_a}), 0);
    reset = 1'b1;
    drive(1'b1, 50);

    s_cv = n_cv_a;
    send_frame(8'h00, 8'hFF, 8'h0C, 8'hF3);
    chk("t1_valid_count", n_cv_a - s_cv, 1);
    chk("t1_led", int'(last_led_a), 8'hF9);
    chk("t1_cmd_held", int'(cmd_a), 8'h0C);

    s_cv = n_cv_a; s_rp = n_rp_a;
    send_frame(8'h00, 8'hFF, 8'h15, 8'hEA);
    send_repeat();
    chk("t2_valid_count", n_cv_a - s_cv, 1);
    chk("t2_led", int'(last_led_a), 8'h86);
    chk("t2_repeat_count", n_rp_a - s_rp, 1);

    s_cv = n_cv_a; s_fe = n_fe_a;
    send_frame(8'h00, 8'hFF, 8'h43, 8'h00);
    chk("t3_err_count", n_fe_a - s_fe, 1);
    chk("t3_valid_count", n_cv_a - s_cv, 0);
    chk("t3_cmd_unchanged", int'(cmd_a), 8'h15);

    s_fe = n_fe_a;
    drive(1'b0, 700);
    ir_in = 1'b1;
    sched(cyc + 4, 3, 3, 8'h00);
    drive(1'b1, 300);
    chk("t4_short_leader_err", n_fe_a - s_fe, 1);
    send_frame(8'h00, 8'hFF, 8'h16, 8'hE9);
    chk("t4_led", int'(last_led_a), 8'hC0);

    s_cv = n_cv_a; s_fe = n_fe_a;
    leader_and_bits({8'hBB, 8'h44, 8'hFF, 8'h00}, 12);
    drive(1'b0, 20);
    reset = 1'b0;
    #1;
    chk("t5_reset_led", int'(led_a), 8'hFF);
    chk("t5_reset_cmd", int'(cmd_a), 8'h00);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 30);
    ir_in = 1'b1;
    sched(cyc + 4, 3, 3, 8'h00);
    drive(1'b1, 300);
    chk("t5_single_err", n_fe_a - s_fe, 1);
    chk("t5_no_strobe", n_cv_a - s_cv, 0);
    send_frame(8'h00, 8'hFF, 8'h44, 8'hBB);
    chk("t5_led_after", int'(last_led_a), 8'hA0);

    s_fe = n_fe_a; s_cvb = n_cv_b; s_ledb = n_led_b;
    send_frame(8'h01, 8'hFE, 8'h99, 8'h66);
    chk("t6_addr_err_a", n_fe_a - s_fe, 1);
    chk("t6_valid_b", n_cv_b - s_cvb, 1);
    chk("t6_cmd_b", int'(cmd_b), 8'h99);
    chk("t6_no_led_b", n_led_b - s_ledb, 0);

    s_feb = n_fe_b;
    drive(1'b0, rr(820, 900));
    ir_in = 1'b1;
    sched(cyc + 1006, 3, 3, 8'h00);
    drive(1'b1, 1200);
    chk("t7_timeout_err", n_fe_b - s_feb, 1);

    for (int k = 0; k < 3; k++) begin
      c = ($urandom_range(1, 0) == 1) ? key_cmd[$urandom_range(14, 0)] : 8'($urandom_range(255, 0));
      a = ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 0)) : TB_ADDR;
      if ($urandom_range(3, 0) == 0) send_frame(a, ~a, c, ~c ^ 8'h10);
      else send_frame(a, ~a, c, ~c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
